// File: rtl/mips_imem_fetch.sv
// mips_imem_fetch
// Clocked instruction memory between the fetch stage and the decoder.
// Byte-addressed word fetch over a valid/ready handshake with one-cycle read
// latency, a program-load write port, post-reset clear sequencing and fault
// reporting for misaligned or out-of-range accesses.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready/req_addr   fetch request channel
//   rsp_valid/rsp_ready/rsp_data/rsp_err  fetch response channel
//                              (rsp_err[0] misaligned, rsp_err[1] out of range)
//   ld_en/ld_ready/ld_addr/ld_data  program-load write channel
//   ld_err                     one-cycle pulse when an accepted load is dropped
//   init_done                  high once the clear sequence has finished
module mips_imem_fetch #(
    parameter int unsigned          DATA_W         = 32,
    parameter int unsigned          ADDR_W         = 32,
    parameter int unsigned          DEPTH          = 1024,
    parameter logic [ADDR_W-1:0]    BASE_ADDR      = '0,
    parameter bit                   CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0]    CLEAR_VALUE    = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_err,
    input  logic              ld_en,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_err,
    output logic              init_done
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned DEC_W = IDX_W + 2;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam logic [0:0] ST_RST   = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

    // Decode a byte address into {out_of_range, misaligned, word_index}.
    // BASE_ADDR is word-aligned, so the offset's low bits give misalignment.
    function automatic logic [DEC_W-1:0] decode(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] off;
        logic              mis;
        logic              oor;
        off = addr - BASE_ADDR;
        mis = (off[1:0] != 2'b00);
        oor = (addr < BASE_ADDR) || (off[ADDR_W-1:IDX_W+2] != '0);
        return {oor, mis, off[IDX_W+1:2]};
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    logic [0:0]        state_q, state_d;
    logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]        rsp_err_q, rsp_err_d;
    logic              ld_err_q, ld_err_d;
    logic              init_done_q, init_done_d;

    logic [DEC_W-1:0]  req_dec;
    logic [DEC_W-1:0]  ld_dec;
    logic              run;
    logic              req_accept;
    logic              ld_accept;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_widx;
    logic [DATA_W-1:0] mem_wdata;

    assign run       = (state_q == ST_RUN);
    assign req_ready = run && (!rsp_valid_q || rsp_ready);
    assign ld_ready  = run;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign ld_err    = ld_err_q;
    assign init_done = init_done_q;

    // State register and response/status flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RST;
            clr_idx_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 2'b00;
            ld_err_q    <= 1'b0;
            init_done_q <= !CLEAR_ON_RESET;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            ld_err_q    <= ld_err_d;
            init_done_q <= init_done_d;
        end
    end

    // Next-state, response and memory-write decisions.
    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        ld_err_d    = 1'b0;
        mem_we      = 1'b0;
        mem_widx    = '0;
        mem_wdata   = '0;

        req_dec    = decode(req_addr);
        ld_dec     = decode(ld_addr);
        req_accept = req_valid && req_ready;
        ld_accept  = ld_en && run;

        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_widx  = clr_idx_q;
                mem_wdata = CLEAR_VALUE;
                clr_idx_d = clr_idx_q + IDX_W'(1);
                if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (ld_accept) begin
                    if (ld_dec[DEC_W-1:DEC_W-2] == 2'b00) begin
                        mem_we    = 1'b1;
                        mem_widx  = ld_dec[IDX_W-1:0];
                        mem_wdata = ld_data;
                    end else begin
                        ld_err_d = 1'b1;
                    end
                end
            end
        endcase

        // Read-first: the array is sampled before this edge's write lands.
        if (req_accept) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = req_dec[DEC_W-1:DEC_W-2];
            rsp_data_d  = (req_dec[DEC_W-1:DEC_W-2] == 2'b00) ? mem[req_dec[IDX_W-1:0]] : '0;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        init_done_d = (state_d == ST_RUN);
    end

    // Storage array; no reset, contents come from the clear sequence or loads.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_mips_imem_fetch.sv
// Directed self-checking bench for mips_imem_fetch (default parameters).
module tb_mips_imem_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_err;
    logic        ld_en = 1'b0;
    logic        ld_ready;
    logic [31:0] ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic        ld_err;
    logic        init_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_imem_fetch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .ld_en     (ld_en),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_err    (ld_err),
        .init_done (init_done)
    );

    // All driver tasks are entered 1 time unit after a rising edge.
    task automatic do_fetch(input logic [31:0] a, output logic v, output logic [31:0] d,
                            output logic [1:0] e);
        req_valid = 1'b1;
        req_addr  = a;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        v = rsp_valid;
        d = rsp_data;
        e = rsp_err;
        @(posedge clk); #1;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] d, output logic le);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
        le = ld_err;
    endtask

    // Counts rising edges from here until init_done is seen high.
    task automatic wait_init(output int cyc, output int busy_bad);
        cyc = 0;
        busy_bad = 0;
        while (init_done !== 1'b1 && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            if (init_done !== 1'b1 && (req_ready !== 1'b0 || ld_ready !== 1'b0)) busy_bad++;
        end
    endtask

    task automatic test_reset;
        int cyc, bad;
        logic v; logic [31:0] d; logic [1:0] e;
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({req_ready, rsp_valid, rsp_data, rsp_err, ld_ready, ld_err, init_done} !== 39'd0) begin
            errors++;
            $display("FAIL reset_values: got rr=%b rv=%b rd=%h re=%b lr=%b le=%b id=%b, want all 0",
                     req_ready, rsp_valid, rsp_data, rsp_err, ld_ready, ld_err, init_done);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_init(cyc, bad);
        checks++;
        if (cyc !== 1024) begin
            errors++;
            $display("FAIL clear_length: init_done after %0d cycles, want 1024", cyc);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL ready_during_clear: %0d cycles with ready high, want 0", bad);
        end
        checks++;
        if (req_ready !== 1'b1 || ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_in_run: req_ready=%b ld_ready=%b, want 1 1", req_ready, ld_ready);
        end
        do_fetch(32'h0000_0FFC, v, d, e);
        checks++;
        if (v !== 1'b1 || d !== 32'h0 || e !== 2'b00) begin
            errors++;
            $display("FAIL fetch_cleared_top: v=%b d=%h e=%b, want 1 00000000 00", v, d, e);
        end
    endtask

    task automatic test_back_to_back;
        logic le;
        do_load(32'h4, 32'h2011_0028, le);
        checks++;
        if (le !== 1'b0) begin
            errors++;
            $display("FAIL load4_err: ld_err=%b, want 0", le);
        end
        do_load(32'h8, 32'h0220_4020, le);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h4;
        @(posedge clk); #1;
        req_addr = 32'h8;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h2011_0028 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: v=%b d=%h rr=%b, want 1 20110028 1", rsp_valid, rsp_data, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h0220_4020) begin
            errors++;
            $display("FAIL b2b_second: v=%b d=%h, want 1 02204020", rsp_valid, rsp_data);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: rsp_valid=%b, want 0", rsp_valid);
        end
    endtask

    task automatic test_backpressure;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h4;
        @(posedge clk); #1;
        req_addr = 32'h8;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'h2011_0028 || rsp_err !== 2'b00 ||
                req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: v=%b d=%h e=%b rr=%b, want 1 20110028 00 0",
                         i, rsp_valid, rsp_data, rsp_err, req_ready);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: req_ready=%b, want 1", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h0220_4020) begin
            errors++;
            $display("FAIL bp_next: v=%b d=%h, want 1 02204020", rsp_valid, rsp_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_faults;
        logic v; logic [31:0] d; logic [1:0] e; logic le;
        logic [31:0] addrs [3];
        logic [1:0]  errs  [3];
        addrs[0] = 32'h6;    errs[0] = 2'b01;
        addrs[1] = 32'h1000; errs[1] = 2'b10;
        addrs[2] = 32'h1002; errs[2] = 2'b11;
        for (int i = 0; i < 3; i++) begin
            do_fetch(addrs[i], v, d, e);
            checks++;
            if (v !== 1'b1 || d !== 32'h0 || e !== errs[i]) begin
                errors++;
                $display("FAIL fault_fetch_%h: v=%b d=%h e=%b, want 1 00000000 %b",
                         addrs[i], v, d, e, errs[i]);
            end
        end
        do_load(32'h1000, 32'hDEAD_BEEF, le);
        checks++;
        if (le !== 1'b1) begin
            errors++;
            $display("FAIL ld_err_pulse: ld_err=%b, want 1", le);
        end
        @(posedge clk); #1;
        checks++;
        if (ld_err !== 1'b0) begin
            errors++;
            $display("FAIL ld_err_clear: ld_err=%b, want 0", ld_err);
        end
        do_fetch(32'h0, v, d, e);
        checks++;
        if (d !== 32'h0 || e !== 2'b00) begin
            errors++;
            $display("FAIL ld_fault_nowrite: d=%h e=%b, want 00000000 00", d, e);
        end
    endtask

    task automatic test_read_first;
        logic v; logic [31:0] d; logic [1:0] e;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h8;
        ld_en     = 1'b1;
        ld_addr   = 32'h8;
        ld_data   = 32'h2009_00AA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        ld_en     = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h0220_4020) begin
            errors++;
            $display("FAIL read_first_old: v=%b d=%h, want 1 02204020", rsp_valid, rsp_data);
        end
        @(posedge clk); #1;
        do_fetch(32'h8, v, d, e);
        checks++;
        if (d !== 32'h2009_00AA) begin
            errors++;
            $display("FAIL read_first_new: d=%h, want 200900aa", d);
        end
    endtask

    task automatic test_reset_midop;
        int cyc, bad;
        logic v; logic [31:0] d; logic [1:0] e;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h4;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL midop_pending: rsp_valid=%b, want 1", rsp_valid);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || init_done !== 1'b0 || req_ready !== 1'b0 || rsp_data !== 32'h0) begin
            errors++;
            $display("FAIL midop_async: rv=%b id=%b rr=%b rd=%h, want 0 0 0 00000000",
                     rsp_valid, init_done, req_ready, rsp_data);
        end
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_init(cyc, bad);
        checks++;
        if (cyc !== 1024 || bad !== 0) begin
            errors++;
            $display("FAIL midop_reclear: %0d cycles, %0d busy errors, want 1024 0", cyc, bad);
        end
        do_fetch(32'h4, v, d, e);
        checks++;
        if (v !== 1'b1 || d !== 32'h0 || e !== 2'b00) begin
            errors++;
            $display("FAIL midop_cleared: v=%b d=%h e=%b, want 1 00000000 00", v, d, e);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_faults();
        test_read_first();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
